// File: rtl/pwm_duty_decoder.sv
// PWM duty decoder: measures high time and period of an asynchronous PWM input and reports
// duty (0..255) via a valid/ready result register. Optional filter: PWM_DEC_GLITCH_FILTER_EN.
`timescale 1ns/1ps
module pwm_duty_decoder #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_in,
  input  logic             ready_in,
  output logic             valid_out,
  output logic [7:0]       duty_out,
  output logic [CNT_W-1:0] period_out,
  output logic             stuck_hi_out,
  output logic             stuck_lo_out,
  output logic             overrun_out
);

  localparam int unsigned      PW     = CNT_W + 1;
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
  localparam logic [CNT_W-1:0] CntTop = ~CntOne;  // one below all-ones

  typedef enum logic [2:0] {StIdle, StHigh, StLow, StStuckHi, StStuckLo} state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_lvl, s, s_q, rise, fall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
  end
  assign sync_lvl = sync_q[SYNC_STAGES-1];

`ifdef PWM_DEC_GLITCH_FILTER_EN
  logic [1:0] hist_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) hist_q <= '0;
    else     hist_q <= {hist_q[0], sync_lvl};
  end
  // Level only follows the synchronizer once it has agreed for three cycles in a row.
  assign s = (sync_lvl == hist_q[0] && sync_lvl == hist_q[1]) ? sync_lvl : s_q;
`else
  assign s = sync_lvl;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) s_q <= 1'b0;
    else     s_q <= s;
  end
  assign rise = s & ~s_q;
  assign fall = ~s & s_q;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d, lcnt_q, lcnt_d;
  logic             capture, stuck_hi_hit, stuck_lo_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      hcnt_q  <= '0;
      lcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      lcnt_q  <= lcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    lcnt_d  = lcnt_q;
    unique case (state_q)
      StIdle: begin
        if (rise) begin
          state_d = StHigh;
          hcnt_d  = CntOne;
          lcnt_d  = CntOne;
        end else if (!s) begin
          lcnt_d = lcnt_q + CntOne;
          if (lcnt_q == CntTop) state_d = StStuckLo;
        end
      end
      StHigh: begin
        if (fall) begin
          state_d = StLow;
          lcnt_d  = CntOne;
        end else begin
          hcnt_d = hcnt_q + CntOne;
          if (hcnt_q == CntTop) state_d = StStuckHi;
        end
      end
      StLow: begin
        if (rise) begin
          state_d = StHigh;
          hcnt_d  = CntOne;
          lcnt_d  = CntOne;
        end else begin
          lcnt_d = lcnt_q + CntOne;
          if (lcnt_q == CntTop) state_d = StStuckLo;
        end
      end
      StStuckHi, StStuckLo: begin
        if (rise) begin
          state_d = StHigh;
          hcnt_d  = CntOne;
          lcnt_d  = CntOne;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    capture      = 1'b0;
    stuck_hi_hit = 1'b0;
    stuck_lo_hit = 1'b0;
    unique case (state_q)
      StIdle: stuck_lo_hit = !s && (lcnt_q == CntTop);
      StHigh: stuck_hi_hit = !fall && (hcnt_q == CntTop);
      StLow: begin
        capture      = rise;
        stuck_lo_hit = !rise && (lcnt_q == CntTop);
      end
      default: ;
    endcase
  end

  // Restoring divider: remainder starts at H (< P), one quotient bit per step.
  logic [PW-1:0]    den_q, den_d, p_sum;
  logic [PW:0]      rem_q, rem_d, rem_sh;
  logic [7:0]       quo_q, quo_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] per_q, per_d;
  logic             done_q, done_d, busy, start, drop, ge;
  logic             stk_hi_q, stk_lo_q;

  assign p_sum  = {1'b0, hcnt_q} + {1'b0, lcnt_q};
  assign busy   = (cnt_q != 4'd0);
  assign start  = capture && !busy;
  assign drop   = capture && busy;
  assign rem_sh = {rem_q[PW-1:0], 1'b0};
  assign ge     = (rem_sh >= {1'b0, den_q});

  always_comb begin
    den_d  = den_q;
    rem_d  = rem_q;
    quo_d  = quo_q;
    cnt_d  = cnt_q;
    per_d  = per_q;
    done_d = busy && (cnt_q == 4'd1);
    if (start) begin
      den_d = p_sum;
      rem_d = {2'b00, hcnt_q};
      quo_d = '0;
      cnt_d = 4'd8;
      per_d = p_sum[CNT_W] ? '1 : p_sum[CNT_W-1:0];
    end else if (busy) begin
      rem_d = ge ? (rem_sh - {1'b0, den_q}) : rem_sh;
      quo_d = {quo_q[6:0], ge};
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      den_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
      per_q    <= '0;
      done_q   <= 1'b0;
      stk_hi_q <= 1'b0;
      stk_lo_q <= 1'b0;
    end else begin
      den_q    <= den_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      cnt_q    <= cnt_d;
      per_q    <= per_d;
      done_q   <= done_d;
      stk_hi_q <= stuck_hi_hit;
      stk_lo_q <= stuck_lo_hit;
    end
  end

  logic             valid_q, valid_d, shi_q, shi_d, slo_q, slo_d, ovr_q, ovr_d, res_load;
  logic [7:0]       duty_q, duty_d;
  logic [CNT_W-1:0] pout_q, pout_d;

  assign res_load = done_q | stk_hi_q | stk_lo_q;

  always_comb begin
    valid_d = valid_q;
    duty_d  = duty_q;
    pout_d  = pout_q;
    shi_d   = shi_q;
    slo_d   = slo_q;
    ovr_d   = ovr_q | drop | (res_load && valid_q && !ready_in);
    if (valid_q && ready_in) valid_d = 1'b0;
    if (done_q) begin
      valid_d = 1'b1;
      duty_d  = quo_q;
      pout_d  = per_q;
      shi_d   = 1'b0;
      slo_d   = 1'b0;
    end else if (stk_hi_q || stk_lo_q) begin
      valid_d = 1'b1;
      duty_d  = stk_hi_q ? 8'hFF : 8'h00;
      pout_d  = '1;
      shi_d   = stk_hi_q;
      slo_d   = stk_lo_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      duty_q  <= '0;
      pout_q  <= '0;
      shi_q   <= 1'b0;
      slo_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      duty_q  <= duty_d;
      pout_q  <= pout_d;
      shi_q   <= shi_d;
      slo_q   <= slo_d;
      ovr_q   <= ovr_d;
    end
  end

  assign valid_out    = valid_q;
  assign duty_out     = duty_q;
  assign period_out   = pout_q;
  assign stuck_hi_out = shi_q;
  assign stuck_lo_out = slo_q;
  assign overrun_out  = ovr_q;

endmodule

// File: doc/pwm_duty_decoder.md
PWM_DUTY_DECODER -- requirements
Module: pwm_duty_decoder

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16: width of the high-time and period counters (range 9..24).
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2: number of synchronizer flops on pwm_in (range 2..3).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, with all flops on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 The block SHALL have port pwm_in, input, 1 bit: PWM waveform, asynchronous to clk.
REQ-006 The block SHALL have port ready_in, input, 1 bit: consumer accepts the result when ready_in and valid_out are both high.
REQ-007 The block SHALL have port valid_out, output, 1 bit: duty_out and period_out hold an unconsumed result.
REQ-008 The block SHALL have port duty_out, output, 8 bits: measured duty, where 0 means 0% and 255 means 100%.
REQ-009 The block SHALL have port period_out, output, CNT_W bits: measured period in clk cycles, or all-ones when stuck.
REQ-010 The block SHALL have ports stuck_hi_out and stuck_lo_out, output, 1 bit each: input held high / held low beyond counter range.
REQ-011 The block SHALL have port overrun_out, output, 1 bit: sticky flag meaning a result was lost.

Function
REQ-012 pwm_in SHALL pass through SYNC_STAGES flops, then the optional filter (REQ-030), producing level s; an edge is detected by comparing s with its previous registered value.
REQ-013 The measurement FSM SHALL have states IDLE, HIGH, LOW, STUCK_HI and STUCK_LO, and SHALL enter IDLE on reset.
REQ-014 IDLE SHALL go to HIGH on a rising edge of s (clearing hcnt and lcnt to 1), and SHALL ignore falling edges.
REQ-015 HIGH SHALL increment hcnt each cycle s=1 and SHALL go to LOW on a falling edge (setting lcnt to 1).
REQ-016 LOW SHALL increment lcnt each cycle s=0; on a rising edge it SHALL capture H=hcnt and P=hcnt+lcnt, start the divider, and go to HIGH with the counters reset.
REQ-017 If hcnt reaches 2^CNT_W-1 in HIGH, the FSM SHALL go to STUCK_HI and emit duty 255, period all-ones, stuck_hi=1, without using the divider.
REQ-018 If lcnt reaches 2^CNT_W-1 in LOW or IDLE, the FSM SHALL go to STUCK_LO and emit duty 0, period all-ones, stuck_lo=1, without using the divider.
REQ-019 On the next rising edge, STUCK_HI/STUCK_LO SHALL behave as IDLE does (go to HIGH) without emitting a result; a stuck result SHALL be emitted once per stuck entry.
REQ-020 The divider SHALL be sequential restoring division, one quotient bit per cycle over 8 cycles, computing duty = floor(H*256/P); since P>H, the result is always in 0..255.
REQ-021 The result register SHALL load duty, P and the stuck flags 1 cycle after the divider finishes and set valid_out; total latency from pwm_in rising to valid_out SHALL be SYNC_STAGES+10 cycles (+2 with the filter).
REQ-022 valid_out SHALL clear on the cycle after a handshake unless a new result loads in the same cycle, in which case valid_out stays high with the new data.
REQ-023 A new result arriving while valid_out=1 and ready_in=0 SHALL overwrite the old result and set overrun_out.
REQ-024 A capture while the divider is busy (P < 9) SHALL be dropped, SHALL set overrun_out, and SHALL still restart the counters.
REQ-025 overrun_out SHALL clear only on reset.
REQ-026 duty_out, period_out and the stuck flags SHALL be stable while valid_out=1 and ready_in=0, except when overwritten per REQ-023.

Reset
REQ-027 While rst=1, all of the following SHALL be held, asynchronously: valid_out=0, duty_out=0, period_out=0, stuck_hi_out=0, stuck_lo_out=0, overrun_out=0, FSM=IDLE, divider idle, counters=0, synchronizer and filter flops=0.
REQ-028 Reset asserted during a division SHALL abort it with no result emitted.
REQ-029 After rst deasserts, the first result SHALL require a full low-to-high-to-low-to-high cycle of s.

Configuration
REQ-030 With macro PWM_DEC_GLITCH_FILTER_EN defined, s SHALL change only after the synchronized input has held the new level for 3 consecutive cycles, adding 2 cycles of latency; without the macro, s SHALL equal the synchronizer output, with no filter logic present.

Verification
REQ-031 Bench SHALL cover: period 16, high 4, ready_in=1 -> one result per period, duty_out=64, period_out=16, flags 0.
REQ-032 Bench SHALL cover: period 1000, high 999 -> duty_out=255 (floor(999*256/1000)=255); period 1000, high 1 -> duty_out=0.
REQ-033 Bench SHALL cover: pwm_in held 1 for 70000 cycles, CNT_W=16 -> one result duty_out=255, period_out=16'hFFFF, stuck_hi_out=1; a later rising edge -> no extra result.
REQ-034 Bench SHALL cover: ready_in=0 across two periods of 32 -> second result overwrites the first, overrun_out=1 and stays 1 until rst.
REQ-035 Bench SHALL cover: rst pulse 3 cycles after a capture -> no valid_out, all outputs 0, and the next result appears only after a full cycle of s.
REQ-036 Bench SHALL cover: a 1-cycle low glitch inside a high phase of a period-64, high-32 signal -> duty_out=128 with PWM_DEC_GLITCH_FILTER_EN defined; a split measurement without it.
